// File: rtl/step_motor_drv.sv
// Stepper pulse generator: turns start/stop/speed/step/dir commands into
// step/dir/enable pins, tracks absolute position and synchronises limit sensors.
module step_motor_drv #(
  parameter int C_STEP_NUMBER_WIDTH = 32,
  parameter int C_SPEED_DATA_WIDTH  = 32,
  parameter int C_SYNC_STAGES       = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           sel,
  input  logic                           start,
  input  logic                           stop,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  speed,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] step,
  input  logic                           dir,
  input  logic                           mod_remain,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] new_remain,
  input  logic                           zpd,
  input  logic                           tpd,
  output logic                           state,
  output logic [C_STEP_NUMBER_WIDTH-1:0] position,
  output logic                           zpsign,
  output logic                           tpsign,
  output logic                           o_step,
  output logic                           o_dir,
  output logic                           o_en
);

  localparam int SW = C_STEP_NUMBER_WIDTH;
  localparam int DW = C_SPEED_DATA_WIDTH;
  localparam int NS = C_SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} fsm_t;

  fsm_t            fsm_reg, fsm_next;
  logic [DW-1:0]   cnt_reg, cnt_next;
  logic [DW-1:0]   hi_len_reg, hi_len_next;
  logic [DW-1:0]   lo_len_reg, lo_len_next;
  logic [SW-1:0]   remain_reg, remain_next;
  logic [SW-1:0]   position_reg, position_next;
  logic            dir_reg, dir_next;
  logic            inf_reg, inf_next;
  logic            stop_reg, stop_next;
  logic            en_reg;
  logic [NS-1:0]   zp_sync_reg, tp_sync_reg;
  logic [NS:0]     zp_tap;

  logic [DW-1:0]   period;
  logic [SW-1:0]   remain_base;
  logic            step_event;
  logic            running;
  logic            blocked;
  logic            limit_hit;
  logic            end_pending;
  logic            zp_rise;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      zp_sync_reg <= '0;
      tp_sync_reg <= '0;
    end else begin
      zp_sync_reg[0] <= zpd;
      tp_sync_reg[0] <= tpd;
      for (int i = 1; i < NS; i++) begin
        zp_sync_reg[i] <= zp_sync_reg[i-1];
        tp_sync_reg[i] <= tp_sync_reg[i-1];
      end
    end
  end

  // Edge is taken one stage early so homing lands on the same edge zpsign rises.
  assign zp_tap  = {zp_sync_reg, zpd};
  assign zp_rise = zp_tap[NS-1] & ~zp_tap[NS];
  assign zpsign  = zp_sync_reg[NS-1];
  assign tpsign  = tp_sync_reg[NS-1];

  assign period      = (speed < DW'(2)) ? DW'(2) : speed;
  assign running     = (fsm_reg != IDLE);
  assign blocked     = dir ? zpsign : tpsign;
  assign limit_hit   = dir_reg ? zpsign : tpsign;
  assign end_pending = stop_reg | stop | limit_hit | (~inf_reg & (remain_reg == '0));

  always_comb begin
    fsm_next      = fsm_reg;
    cnt_next      = cnt_reg;
    hi_len_next   = hi_len_reg;
    lo_len_next   = lo_len_reg;
    remain_next   = remain_reg;
    position_next = position_reg;
    dir_next      = dir_reg;
    inf_next      = inf_reg;
    stop_next     = stop_reg;
    remain_base   = remain_reg;
    step_event    = 1'b0;

    case (fsm_reg)
      IDLE: begin
        if (start && sel && !stop && !blocked) begin
          fsm_next    = HIGH;
          cnt_next    = '0;
          hi_len_next = period >> 1;
          lo_len_next = period - (period >> 1);
          dir_next    = dir;
          inf_next    = (step == '0);
          remain_base = step;
          step_event  = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_reg == hi_len_reg - DW'(1)) begin
          fsm_next = LOW;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + DW'(1);
        end
      end
      LOW: begin
        if (cnt_reg == lo_len_reg - DW'(1)) begin
          cnt_next = '0;
          if (end_pending) begin
            fsm_next = IDLE;
          end else begin
            fsm_next   = HIGH;
            step_event = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + DW'(1);
        end
      end
      default: fsm_next = IDLE;
    endcase

    if (step_event) begin
      position_next = dir_next ? position_reg - SW'(1) : position_reg + SW'(1);
      remain_next   = inf_next ? remain_base : remain_base - SW'(1);
    end

    // Overrides below are ordered by priority, lowest first.
    if (running && mod_remain) begin
      remain_next = new_remain;
      inf_next    = 1'b0;
    end
    if (running && dir_reg && zp_rise)
      position_next = '0;
    if (running && stop)
      stop_next = 1'b1;
    if (fsm_next == IDLE)
      stop_next = 1'b0;

    if (!sel) begin
      fsm_next      = IDLE;
      cnt_next      = '0;
      stop_next     = 1'b0;
      position_next = position_reg;
      remain_next   = remain_reg;
      inf_next      = inf_reg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_reg      <= IDLE;
      cnt_reg      <= '0;
      hi_len_reg   <= '0;
      lo_len_reg   <= '0;
      remain_reg   <= '0;
      position_reg <= '0;
      dir_reg      <= 1'b0;
      inf_reg      <= 1'b0;
      stop_reg     <= 1'b0;
      en_reg       <= 1'b0;
    end else begin
      fsm_reg      <= fsm_next;
      cnt_reg      <= cnt_next;
      hi_len_reg   <= hi_len_next;
      lo_len_reg   <= lo_len_next;
      remain_reg   <= remain_next;
      position_reg <= position_next;
      dir_reg      <= dir_next;
      inf_reg      <= inf_next;
      stop_reg     <= stop_next;
      en_reg       <= sel;
    end
  end

  assign state    = running;
  assign o_step   = (fsm_reg == HIGH);
  assign o_dir    = dir_reg;
  assign o_en     = en_reg;
  assign position = position_reg;

endmodule
